// File: rtl/fila_notas_buzzer.sv
// rtl/fila_notas_buzzer.sv - note FIFO and sequencer driving the buzzer tone generator
// Queued notes play back-to-back; each note is followed by a fixed silent gap.
module fila_notas_buzzer #(
    parameter int CLOCK_FREQ   = 50000000,
    parameter int TOM          = 4,
    parameter int UNIDADE_MS   = 100,
    parameter int PAUSA_MS     = 20,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   escreve,
    input  logic [3:0]             nota_in,
    input  logic [$clog2(TOM)-1:0] tom_in,
    input  logic [1:0]             duracao_in,
    input  logic                   para,
    output logic                   cheio,
    output logic                   vazio,
    output logic                   descartado,
    output logic                   toca,
    output logic [3:0]             seletor,
    output logic [$clog2(TOM)-1:0] tom,
    output logic                   tocando,
    output logic                   fim_nota
);

    localparam int U     = CLOCK_FREQ / 1000 * UNIDADE_MS;
    localparam int P     = CLOCK_FREQ / 1000 * PAUSA_MS;
    localparam int TMR_W = $clog2(U * 8 + 1);
    localparam int PTR_W = $clog2(PROFUNDIDADE);
    localparam int CNT_W = PTR_W + 1;
    localparam int TOM_W = $clog2(TOM);
    localparam int ENT_W = 4 + TOM_W + 2;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        TOCA    = 2'd2,
        PAUSA   = 2'd3
    } estado_t;

    estado_t estado_q, estado_d;

    logic [ENT_W-1:0] fifo_mem_q [PROFUNDIDADE];
    logic [ENT_W-1:0] entrada_d;
    logic [ENT_W-1:0] cabeca;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cheio_q, cheio_d;
    logic             vazio_q, vazio_d;
    logic             descartado_q, descartado_d;
    logic [3:0]       seletor_q, seletor_d;
    logic [TOM_W-1:0] tom_q, tom_d;
    logic [1:0]       duracao_q, duracao_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             toca_q, toca_d;
    logic             tocando_q, tocando_d;
    logic             fim_nota_q, fim_nota_d;

    logic push;
    logic pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        if (para) begin
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO:  if (!vazio_q) estado_d = CARREGA;
                CARREGA: estado_d = TOCA;
                TOCA:    if (timer_q == '0) estado_d = PAUSA;
                PAUSA:   if (timer_q == '0) estado_d = OCIOSO;
                default: estado_d = OCIOSO;
            endcase
        end
    end

    // cheio_q is the pre-edge occupancy, so a push while full is dropped even if a pop coincides
    always_comb begin
        push      = escreve && !cheio_q && !para;
        pop       = (estado_q == OCIOSO) && !vazio_q && !para;
        entrada_d = {nota_in, tom_in, duracao_in};
        cabeca    = fifo_mem_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (para) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        cheio_d      = (count_d == CNT_W'(PROFUNDIDADE));
        vazio_d      = (count_d == '0);
        descartado_d = escreve && cheio_q && !para;

        seletor_d = seletor_q;
        tom_d     = tom_q;
        duracao_d = duracao_q;
        if (pop) begin
            seletor_d = cabeca[ENT_W-1 -: 4];
            tom_d     = cabeca[2 +: TOM_W];
            duracao_d = cabeca[1:0];
        end
    end

    // Outputs are registered from the current state, so they trail the FSM by one cycle
    always_comb begin
        timer_d    = timer_q;
        toca_d     = 1'b0;
        tocando_d  = 1'b0;
        fim_nota_d = 1'b0;
        case (estado_q)
            CARREGA: begin
                timer_d   = (TMR_W'(U) << duracao_q) - TMR_W'(1);
                tocando_d = 1'b1;
            end
            TOCA: begin
                timer_d   = (timer_q == '0) ? TMR_W'(P - 1) : timer_q - TMR_W'(1);
                toca_d    = (seletor_q < 4'd12);
                tocando_d = 1'b1;
            end
            PAUSA: begin
                timer_d    = (timer_q == '0) ? '0 : timer_q - TMR_W'(1);
                tocando_d  = 1'b1;
                fim_nota_d = (timer_q == '0);
            end
            default: timer_d = '0;
        endcase
        if (para) begin
            timer_d    = '0;
            toca_d     = 1'b0;
            tocando_d  = 1'b0;
            fim_nota_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cheio_q      <= 1'b0;
            vazio_q      <= 1'b1;
            descartado_q <= 1'b0;
            seletor_q    <= '0;
            tom_q        <= '0;
            duracao_q    <= '0;
            timer_q      <= '0;
            toca_q       <= 1'b0;
            tocando_q    <= 1'b0;
            fim_nota_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cheio_q      <= cheio_d;
            vazio_q      <= vazio_d;
            descartado_q <= descartado_d;
            seletor_q    <= seletor_d;
            tom_q        <= tom_d;
            duracao_q    <= duracao_d;
            timer_q      <= timer_d;
            toca_q       <= toca_d;
            tocando_q    <= tocando_d;
            fim_nota_q   <= fim_nota_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_mem_q[wr_ptr_q] <= entrada_d;
        end
    end

    assign cheio      = cheio_q;
    assign vazio      = vazio_q;
    assign descartado = descartado_q;
    assign toca       = toca_q;
    assign seletor    = seletor_q;
    assign tom        = tom_q;
    assign tocando    = tocando_q;
    assign fim_nota   = fim_nota_q;

endmodule

// File: tb/tb_fila_notas_buzzer.sv
// tb/tb_fila_notas_buzzer.sv - directed scoreboard bench for fila_notas_buzzer
// U=2 and P=1 ticks; every completed note is popped from the scoreboard at fim_nota.
module tb_fila_notas_buzzer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       escreve = 1'b0;
    logic [3:0] nota_in = '0;
    logic [1:0] tom_in = '0;
    logic [1:0] duracao_in = '0;
    logic       para = 1'b0;
    logic       cheio, vazio, descartado, toca, tocando, fim_nota;
    logic [3:0] seletor;
    logic [1:0] tom;

    int total = 0;
    int bad = 0;

    logic [7:0] sb_q[$];
    int         gaps_q[$];
    int         toca_cnt = 0;
    int         tocando_cnt = 0;
    int         low_run = 0;
    bit         have_fall = 0;
    bit         prev_toca = 0;

    fila_notas_buzzer #(
        .CLOCK_FREQ(1000),
        .TOM(4),
        .UNIDADE_MS(2),
        .PAUSA_MS(1),
        .PROFUNDIDADE(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .escreve(escreve),
        .nota_in(nota_in),
        .tom_in(tom_in),
        .duracao_in(duracao_in),
        .para(para),
        .cheio(cheio),
        .vazio(vazio),
        .descartado(descartado),
        .toca(toca),
        .seletor(seletor),
        .tom(tom),
        .tocando(tocando),
        .fim_nota(fim_nota)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_note(input logic [3:0] n, input logic [1:0] t, input logic [1:0] d,
                             input bit dropped);
        escreve    = 1'b1;
        nota_in    = n;
        tom_in     = t;
        duracao_in = d;
        if (!dropped) sb_q.push_back({n, t, d});
        tick();
        escreve = 1'b0;
    endtask

    task automatic wait_fim(input string tag, input int budget);
        int n = 0;
        while (fim_nota !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, fim_nota, 1);
    endtask

    // Scoreboard: toca cycles = U*2^d for notes 0-11, tocando spans CARREGA + TOCA + PAUSA
    always @(negedge clock) begin
        logic [7:0] e;
        int exp_toca;
        if (reset) begin
            toca_cnt    = 0;
            tocando_cnt = 0;
            low_run     = 0;
            have_fall   = 0;
            prev_toca   = 0;
        end else begin
            if (tocando) tocando_cnt++;
            if (toca) toca_cnt++;
            if (toca && !prev_toca && have_fall) gaps_q.push_back(low_run);
            if (!toca && prev_toca) have_fall = 1;
            if (toca) low_run = 0;
            else low_run++;
            prev_toca = toca;
            if (fim_nota) begin
                if (sb_q.size() == 0) begin
                    chk("fim_unexpected", fim_nota, 0);
                end else begin
                    e = sb_q.pop_front();
                    exp_toca = (e[7:4] < 4'd12) ? (2 << e[1:0]) : 0;
                    chk("sb_seletor", seletor, e[7:4]);
                    chk("sb_tom", tom, e[3:2]);
                    chk("sb_toca_len", toca_cnt, exp_toca);
                    chk("sb_tocando_len", tocando_cnt, 2 + (2 << e[1:0]));
                end
                toca_cnt    = 0;
                tocando_cnt = 0;
            end else if (!tocando) begin
                toca_cnt    = 0;
                tocando_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_fim;
        bit saw_toc;

        repeat (3) tick();
        chk("rst_toca", toca, 0);
        chk("rst_seletor", seletor, 0);
        chk("rst_tom", tom, 0);
        chk("rst_tocando", tocando, 0);
        chk("rst_fim", fim_nota, 0);
        chk("rst_descartado", descartado, 0);
        chk("rst_cheio", cheio, 0);
        chk("rst_vazio", vazio, 1);
        reset = 1'b0;
        repeat (2) tick();

        // 1: single short note, latency and latched fields
        push_note(4'd5, 2'd2, 2'd0, 0);
        chk("t1_vazio_after_push", vazio, 0);
        chk("t1_toca_k", toca, 0);
        tick();
        chk("t1_seletor", seletor, 5);
        chk("t1_tom", tom, 2);
        chk("t1_toca_k1", toca, 0);
        tick();
        chk("t1_toca_k2", toca, 0);
        chk("t1_tocando_k2", tocando, 1);
        tick();
        chk("t1_toca_k3", toca, 1);
        tick();
        chk("t1_toca_k4", toca, 1);
        tick();
        chk("t1_toca_k5", toca, 0);
        chk("t1_fim_k5", fim_nota, 1);
        tick();
        chk("t1_fim_k6", fim_nota, 0);
        chk("t1_vazio_end", vazio, 1);
        chk("t1_sb_empty", sb_q.size(), 0);

        // 2: longest duration
        push_note(4'd11, 2'd1, 2'd3, 0);
        wait_fim("t2_fim", 40);
        tick();
        chk("t2_sb_empty", sb_q.size(), 0);
        repeat (2) tick();

        // 3: overflow while busy, then ordered back-to-back playback
        push_note(4'd1, 2'd0, 2'd1, 0);
        tick();
        push_note(4'd2, 2'd1, 2'd0, 0);
        push_note(4'd3, 2'd2, 2'd1, 0);
        push_note(4'd4, 2'd3, 2'd0, 0);
        chk("t3_cheio_3", cheio, 0);
        push_note(4'd6, 2'd0, 2'd0, 0);
        chk("t3_cheio_4", cheio, 1);
        chk("t3_descartado_pre", descartado, 0);
        push_note(4'd7, 2'd1, 2'd0, 1);
        chk("t3_descartado", descartado, 1);
        gaps_q.delete();
        tick();
        chk("t3_descartado_once", descartado, 0);
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) tick();
        chk("t3_sb_drain", sb_q.size(), 0);
        chk("t3_gap_count", gaps_q.size(), 4);
        foreach (gaps_q[i]) chk($sformatf("t3_gap%0d", i), gaps_q[i], 3);
        repeat (3) tick();

        // 4: rest keeps toca low but still completes
        push_note(4'd13, 2'd3, 2'd1, 0);
        wait_fim("t4_fim", 30);
        tick();
        chk("t4_sb_empty", sb_q.size(), 0);
        repeat (2) tick();

        // 5: flush during TOCA, push in the same cycle is silently discarded
        push_note(4'd8, 2'd0, 2'd2, 0);
        push_note(4'd9, 2'd1, 2'd0, 0);
        push_note(4'd10, 2'd2, 2'd0, 0);
        repeat (2) tick();
        chk("t5_toca_pre", toca, 1);
        chk("t5_vazio_pre", vazio, 0);
        para       = 1'b1;
        escreve    = 1'b1;
        nota_in    = 4'd5;
        tom_in     = 2'd1;
        duracao_in = 2'd0;
        sb_q.delete();
        tick();
        para    = 1'b0;
        escreve = 1'b0;
        chk("t5_toca", toca, 0);
        chk("t5_vazio", vazio, 1);
        chk("t5_tocando", tocando, 0);
        chk("t5_descartado", descartado, 0);
        chk("t5_fim", fim_nota, 0);
        saw_fim = 0;
        saw_toc = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            saw_fim |= fim_nota;
            saw_toc |= tocando;
        end
        chk("t5_no_fim", saw_fim, 0);
        chk("t5_idle", saw_toc, 0);
        push_note(4'd0, 2'd1, 2'd0, 0);
        wait_fim("t5_fim_after", 20);
        tick();
        chk("t5_sb_empty", sb_q.size(), 0);
        repeat (2) tick();

        // 6: reset mid-note with entries queued
        push_note(4'd2, 2'd2, 2'd1, 0);
        push_note(4'd3, 2'd3, 2'd0, 0);
        push_note(4'd4, 2'd0, 2'd0, 0);
        tick();
        chk("t6_toca_pre", toca, 1);
        chk("t6_vazio_pre", vazio, 0);
        reset = 1'b1;
        sb_q.delete();
        tick();
        chk("t6_toca", toca, 0);
        chk("t6_vazio", vazio, 1);
        chk("t6_seletor", seletor, 0);
        chk("t6_tom", tom, 0);
        chk("t6_tocando", tocando, 0);
        reset = 1'b0;
        saw_toc = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            saw_toc |= tocando;
        end
        chk("t6_idle", saw_toc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fila_notas_buzzer.md
Name: fila_notas_buzzer

Overview:
- Note sequencer placed directly upstream of the buzzer tone generator. It drives the buzzer's toca, seletor and tom inputs.
- Game/control logic pushes notes into a small FIFO. Each note carries a note index, a tone bank and a duration code.
- The block plays queued notes back-to-back. Each note sounds for its timed duration and is followed by a fixed silent gap.
- It reports full/empty status and emits a pulse after each completed note.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz.
TOM, 4, number of tone banks; tone fields are $clog2(TOM) bits wide.
UNIDADE_MS, 100, base duration unit in ms. Unit ticks U = CLOCK_FREQ/1000*UNIDADE_MS.
PAUSA_MS, 20, silent gap after every note in ms. Gap ticks P = CLOCK_FREQ/1000*PAUSA_MS. P must be at least 1.
PROFUNDIDADE, 4, FIFO depth in entries; must be a power of 2, at least 2.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
escreve  in  1  push request, sampled each rising edge
nota_in  in  4  note index; 0-11 are valid notes, 12-15 are rests
tom_in  in  $clog2(TOM)  tone bank
duracao_in  in  2  duration code d; note length = U*2^d ticks
para  in  1  synchronous flush/stop
cheio  out  1  FIFO full
vazio  out  1  FIFO empty
descartado  out  1  one-cycle pulse when a push is dropped
toca  out  1  to buzzer toca
seletor  out  4  to buzzer seletor
tom  out  $clog2(TOM)  to buzzer tom
tocando  out  1  high while in CARREGA, TOCA or PAUSA
fim_nota  out  1  one-cycle pulse at the end of each note's gap

Behaviour:
- Reset: FIFO emptied, FSM in OCIOSO, timer cleared. Outputs after reset: toca=0, seletor=0, tom=0, tocando=0, fim_nota=0, descartado=0, cheio=0, vazio=1.
- FIFO entry is {nota, tom, duracao}. cheio and vazio are registered from the occupancy count.
- Push: escreve=1 with cheio=0 writes an entry at the edge.
- Push when full: escreve=1 with cheio=1 drops the data and descartado=1 for the next cycle. This applies even if a pop happens in the same cycle, because cheio reflects the count before the edge.
- Pop occurs only on the OCIOSO->CARREGA transition. A simultaneous push and pop leaves the count unchanged.
- Read/write pointers wrap modulo PROFUNDIDADE.
- FSM states:
  - OCIOSO: if vazio=0, go to CARREGA, pop the head entry and latch it into seletor, tom and the duration register. Otherwise stay in OCIOSO.
  - CARREGA: lasts 1 cycle. Loads the timer with U*2^d-1, then goes to TOCA.
  - TOCA: timer decrements each cycle. toca=1 only if the latched note is below 12; rests keep toca=0. At timer=0, load the timer with P-1 and go to PAUSA.
  - PAUSA: toca=0; timer decrements. At timer=0, fim_nota=1 for that one cycle and go to OCIOSO.
- Note duration: toca is high for exactly U*2^d consecutive cycles.
- Latency: with escreve asserted at edge k on an empty FIFO, toca rises after edge k+3.
- Back-to-back notes: consecutive notes are separated by exactly P+2 cycles of toca=0 (PAUSA, then OCIOSO, then CARREGA).
- seletor and tom hold their last latched values in OCIOSO and change only at a pop.
- Timer width: $clog2(U*8+1) bits, so the maximum U*8 fits without overflow.
- para=1:
  - FIFO is cleared and the FSM goes to OCIOSO at the next edge; toca=0 from then on.
  - No fim_nota pulse is generated for the aborted note.
  - A push in the same cycle as para is discarded silently (no descartado).
- reset has priority over para, which has priority over escreve.
- Reset mid-note: toca=0 at the next edge and all state returns to reset values.

Test Plan (bench uses CLOCK_FREQ=1000, UNIDADE_MS=2, PAUSA_MS=1, so U=2 and P=1; PROFUNDIDADE=4):
1. Push nota=5, tom=2, d=0 into an empty FIFO -> toca high for exactly 2 cycles starting 3 cycles after the push, seletor=5, tom=2, fim_nota pulse 1 cycle after toca falls, vazio=1 at the end.
2. Push d=3, nota=11 -> toca high for 16 cycles; tocando high for 18 cycles (CARREGA + TOCA + PAUSA).
3. Push 5 notes on consecutive cycles while the FSM is busy with an earlier note -> cheio=1 after 4 entries, descartado pulses once for the 5th; the 4 queued notes then play in order, separated by 3 idle cycles each.
4. Push nota=13, d=1 -> tocando high, toca stays 0 for 4 cycles, fim_nota still pulses.
5. Queue 3 notes, assert para during the first note's TOCA -> toca=0 next cycle, vazio=1, no fim_nota, FSM in OCIOSO; a subsequent push plays normally.
6. Assert reset mid-TOCA with 2 entries queued -> next cycle toca=0, vazio=1, seletor=0, tom=0, tocando=0.
